// File: rtl/imem_sync_loader_if.sv
// Bus interface for imem_sync_loader: read port and loader handshake.
//   AD/RE    -> read address / read enable
//   Q/QV     <- registered read data / one-cycle valid
//   LD_START -> request a full-memory load
//   LD_DATA/LD_VALID -> load word stream, LD_READY <- loader accepting
//   LD_DONE  <- one-cycle load-complete pulse, BUSY <- load in progress
//   LD_SUM   <- load checksum (zero unless IMEM_CHKSUM_EN is defined)
// Modports: slave (the memory), master (the driver of reads and loads).
interface imem_sync_loader_if #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] AD;
   logic              RE;
   logic [DATA_W-1:0] Q;
   logic              QV;
   logic              LD_START;
   logic [DATA_W-1:0] LD_DATA;
   logic              LD_VALID;
   logic              LD_READY;
   logic              LD_DONE;
   logic              BUSY;
   logic [DATA_W-1:0] LD_SUM;

   modport slave (
      input  AD, RE, LD_START, LD_DATA, LD_VALID,
      output Q, QV, LD_READY, LD_DONE, BUSY, LD_SUM
   );

   modport master (
      output AD, RE, LD_START, LD_DATA, LD_VALID,
      input  Q, QV, LD_READY, LD_DONE, BUSY, LD_SUM
   );
endinterface

// File: rtl/imem_sync_loader.sv
// Instruction memory with a sequential full-memory loader.
// Holds 2**ADDR_W words of DATA_W bits, all zero (NOP) at time zero.
// A load (LD_START in IDLE) streams LD_DATA words into addresses 0..DEPTH-1
// under LD_VALID; LD_DONE pulses once after the last word. Reads (RE in
// IDLE) return mem[AD] on Q with QV one cycle later; reads while busy are
// dropped and Q holds.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset (memory contents are kept)
//   bus  - imem_sync_loader_if slave modport (read port + loader handshake)
// Optional feature: define IMEM_CHKSUM_EN to accumulate LD_SUM, the modulo
// 2**DATA_W sum of the words accepted during the latest load. Undefined,
// LD_SUM is tied to zero.
module imem_sync_loader #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 6
) (
   input logic                CLK,
   input logic                RST,
   imem_sync_loader_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] q_r;
   logic              qv_r;
   logic              ready_r;
   logic              done_r;
   logic              busy_r;
   logic              wr_en;

   // Reset forces IDLE asynchronously, so no write can slip through while
   // RST is high.
   assign wr_en = (state == LOAD) && bus.LD_VALID;

   // Memory array has no reset: contents survive RST.
   always_ff @(posedge CLK) begin
      if (wr_en)
         mem[ptr] <= bus.LD_DATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         ptr     <= '0;
         q_r     <= '0;
         qv_r    <= 1'b0;
         ready_r <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         qv_r   <= 1'b0;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               // A read and a load start in the same cycle are both honoured.
               if (bus.RE) begin
                  q_r  <= mem[bus.AD];
                  qv_r <= 1'b1;
               end
               if (bus.LD_START) begin
                  state   <= LOAD;
                  ptr     <= '0;
                  ready_r <= 1'b1;
                  busy_r  <= 1'b1;
               end
            end
            LOAD: begin
               if (bus.LD_VALID) begin
                  ptr <= ptr + 1'b1;
                  if (ptr == '1) begin
                     state   <= DONE;
                     ready_r <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               ready_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Q        = q_r;
   assign bus.QV       = qv_r;
   assign bus.LD_READY = ready_r;
   assign bus.LD_DONE  = done_r;
   assign bus.BUSY     = busy_r;

`ifdef IMEM_CHKSUM_EN
   logic [DATA_W-1:0] sum_r;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         sum_r <= '0;
      else if (state == IDLE && bus.LD_START)
         sum_r <= '0;
      else if (wr_en)
         sum_r <= sum_r + bus.LD_DATA;
   end

   assign bus.LD_SUM = sum_r;
`else
   assign bus.LD_SUM = '0;
`endif
endmodule

// File: tb/tb_imem_sync_loader.sv
module tb_imem_sync_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   imem_sync_loader_if #(.DATA_W(10), .ADDR_W(6)) bus ();

   imem_sync_loader #(.DATA_W(10), .ADDR_W(6)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      bus.AD = '0; bus.RE = 1'b0; bus.LD_START = 1'b0;
      bus.LD_DATA = '0; bus.LD_VALID = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.Q !== 10'd0) begin fails++; $display("FAIL reset_q got %0d want 0", bus.Q); end
      tests++; if (bus.QV !== 1'b0) begin fails++; $display("FAIL reset_qv got %b want 0", bus.QV); end
      tests++; if (bus.LD_DONE !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.LD_DONE); end
      tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
      tests++; if (bus.LD_READY !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", bus.LD_READY); end
      tests++; if (bus.LD_SUM !== 10'd0) begin fails++; $display("FAIL reset_sum got %0d want 0", bus.LD_SUM); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_read_nop();
      @(negedge clk); bus.RE = 1'b1; bus.AD = 6'd5;
      @(posedge clk); #1;
      tests++; if (bus.Q !== 10'd0) begin fails++; $display("FAIL nop_q got %0d want 0", bus.Q); end
      tests++; if (bus.QV !== 1'b1) begin fails++; $display("FAIL nop_qv got %b want 1", bus.QV); end
      @(negedge clk); bus.RE = 1'b0;
      @(posedge clk); #1;
      tests++; if (bus.QV !== 1'b0) begin fails++; $display("FAIL nop_qv_drop got %b want 0", bus.QV); end
   endtask

   task automatic test_reset_abort();
      @(negedge clk); bus.LD_START = 1'b1;
      @(negedge clk); bus.LD_START = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.LD_VALID = 1'b1; bus.LD_DATA = 10'h3FF;
         @(negedge clk);
      end
      // Word 10 is on the bus when reset hits: it must not be written.
      #1 rst = 1'b1;
      #1;
      tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", bus.BUSY); end
      tests++; if (bus.LD_READY !== 1'b0) begin fails++; $display("FAIL abort_ready got %b want 0", bus.LD_READY); end
      @(negedge clk); rst = 1'b0; bus.LD_VALID = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         tests++; if (bus.LD_DONE !== 1'b0) begin fails++; $display("FAIL abort_done cycle %0d got %b want 0", c, bus.LD_DONE); end
      end
      @(negedge clk); bus.RE = 1'b1; bus.AD = 6'd9;
      @(posedge clk); #1;
      tests++; if (bus.Q !== 10'h3FF) begin fails++; $display("FAIL abort_rd9 got %0h want 3ff", bus.Q); end
      @(negedge clk); bus.AD = 6'd10;
      @(posedge clk); #1;
      tests++; if (bus.Q !== 10'd0) begin fails++; $display("FAIL abort_rd10 got %0h want 0", bus.Q); end
      tests++; if (bus.QV !== 1'b1) begin fails++; $display("FAIL abort_qv got %b want 1", bus.QV); end
      @(negedge clk); bus.RE = 1'b0;
   endtask

   task automatic test_full_load();
      logic [9:0] sum = '0;
      logic [9:0] exp_sum;
      @(negedge clk); bus.LD_START = 1'b1;
      @(posedge clk); #1;
      tests++; if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL load_busy_start got %b want 1", bus.BUSY); end
      @(negedge clk); bus.LD_START = 1'b0;
      for (int i = 0; i < 64; i++) begin
         bus.LD_VALID = 1'b1; bus.LD_DATA = 10'(i); sum = sum + 10'(i);
         tests++; if (bus.LD_READY !== 1'b1) begin fails++; $display("FAIL load_ready word %0d got %b want 1", i, bus.LD_READY); end
         @(posedge clk); #1;
         tests++; if (bus.LD_DONE !== (i == 63)) begin fails++; $display("FAIL load_done word %0d got %b want %b", i, bus.LD_DONE, (i == 63)); end
         tests++; if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL load_busy word %0d got %b want 1", i, bus.BUSY); end
         @(negedge clk);
      end
      bus.LD_VALID = 1'b0;
      tests++; if (bus.LD_READY !== 1'b0) begin fails++; $display("FAIL load_ready_done got %b want 0", bus.LD_READY); end
      @(posedge clk); #1;
      tests++; if (bus.LD_DONE !== 1'b0) begin fails++; $display("FAIL load_done_pulse got %b want 0", bus.LD_DONE); end
      tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL load_busy_end got %b want 0", bus.BUSY); end
`ifdef IMEM_CHKSUM_EN
      exp_sum = sum;
`else
      exp_sum = '0;
`endif
      tests++; if (bus.LD_SUM !== exp_sum) begin fails++; $display("FAIL load_sum got %0d want %0d", bus.LD_SUM, exp_sum); end
      @(negedge clk); bus.RE = 1'b1; bus.AD = 6'd42;
      @(posedge clk); #1;
      tests++; if (bus.Q !== 10'd42) begin fails++; $display("FAIL load_rd42 got %0d want 42", bus.Q); end
      tests++; if (bus.QV !== 1'b1) begin fails++; $display("FAIL load_rd42_qv got %b want 1", bus.QV); end
      @(negedge clk); bus.RE = 1'b0;
   endtask

   // Read and load start together, then a stalled load with reads and a
   // stray LD_START issued throughout; stall cycles carry junk data.
   task automatic test_stall_load();
      logic [9:0] sum = '0;
      logic [9:0] exp_sum;
      @(negedge clk); bus.RE = 1'b1; bus.AD = 6'd42; bus.LD_START = 1'b1;
      @(posedge clk); #1;
      tests++; if (bus.Q !== 10'd42) begin fails++; $display("FAIL start_rd_q got %0d want 42", bus.Q); end
      tests++; if (bus.QV !== 1'b1) begin fails++; $display("FAIL start_rd_qv got %b want 1", bus.QV); end
      tests++; if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL start_rd_busy got %b want 1", bus.BUSY); end
      @(negedge clk); bus.LD_START = 1'b0; bus.AD = 6'd0;
      for (int k = 0; k < 128; k++) begin
         bus.LD_VALID = (k % 2 == 0);
         bus.LD_DATA  = (k % 2 == 0) ? 10'(k / 2 + 100) : 10'h2AA;
         bus.LD_START = (k == 40);
         if (k % 2 == 0) sum = sum + 10'(k / 2 + 100);
         if (k <= 126) begin
            tests++; if (bus.LD_READY !== 1'b1) begin fails++; $display("FAIL stall_ready k %0d got %b want 1", k, bus.LD_READY); end
         end
         @(posedge clk); #1;
         tests++; if (bus.LD_DONE !== (k == 126)) begin fails++; $display("FAIL stall_done k %0d got %b want %b", k, bus.LD_DONE, (k == 126)); end
         tests++; if (bus.BUSY !== (k <= 126)) begin fails++; $display("FAIL stall_busy k %0d got %b want %b", k, bus.BUSY, (k <= 126)); end
         tests++; if (bus.QV !== 1'b0 || bus.Q !== 10'd42) begin fails++; $display("FAIL stall_read k %0d got qv %b q %0d want qv 0 q 42", k, bus.QV, bus.Q); end
         @(negedge clk);
      end
      bus.LD_VALID = 1'b0; bus.LD_START = 1'b0; bus.RE = 1'b0;
`ifdef IMEM_CHKSUM_EN
      exp_sum = sum;
`else
      exp_sum = '0;
`endif
      tests++; if (bus.LD_SUM !== exp_sum) begin fails++; $display("FAIL stall_sum got %0d want %0d", bus.LD_SUM, exp_sum); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] addrs [4] = '{6'd1, 6'd2, 6'd3, 6'd63};
      logic [9:0] exp   [4] = '{10'd101, 10'd102, 10'd103, 10'd163};
      for (int n = 0; n < 4; n++) begin
         @(negedge clk); bus.RE = 1'b1; bus.AD = addrs[n];
         @(posedge clk); #1;
         tests++; if (bus.Q !== exp[n] || bus.QV !== 1'b1) begin fails++; $display("FAIL b2b ad %0d got q %0d qv %b want q %0d qv 1", addrs[n], bus.Q, bus.QV, exp[n]); end
      end
      @(negedge clk); bus.RE = 1'b0; bus.AD = 6'd0;
      @(posedge clk); #1;
      tests++; if (bus.QV !== 1'b0 || bus.Q !== 10'd163) begin fails++; $display("FAIL b2b_hold got q %0d qv %b want q 163 qv 0", bus.Q, bus.QV); end
   endtask

   initial begin
      test_reset();
      test_read_nop();
      test_reset_abort();
      test_full_load();
      test_stall_load();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1);
   end
endmodule
